// File: rtl/tinker_mem_responder.sv
// Memory-side responder for the Tinker core: big-endian unified byte store serving
// fetch32 / load64 / store64 requests one byte per cycle over valid/ready channels.
module tinker_mem_responder #(
  parameter int unsigned MEM_SIZE = 524288,
  parameter int unsigned ADDR_W   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int unsigned MemAw = $clog2(MEM_SIZE);
  localparam logic [1:0] OpFetch   = 2'b00;
  localparam logic [1:0] OpStore   = 2'b10;
  localparam logic [1:0] OpIllegal = 2'b11;
  // Highest legal start address per access size; avoids computing addr+N in ADDR_W bits.
  localparam logic [ADDR_W-1:0] LimFetch = ADDR_W'(MEM_SIZE - 4);
  localparam logic [ADDR_W-1:0] LimWide  = ADDR_W'(MEM_SIZE - 8);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  logic [7:0] bytes [MEM_SIZE];

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [MemAw-1:0] addr_q, addr_d;
  logic [63:0]      wdata_q, wdata_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [63:0]      shift_q, shift_d;
  logic [63:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             acc_err;
  logic             last;
  logic [MemAw-1:0] mem_idx;
  logic [7:0]       rd_byte;
  logic             mem_we;

  // Accepted requests always pass the range check, so only the low address bits are kept.
  assign acc_err = (req_op == OpIllegal) ||
                   (req_addr > ((req_op == OpFetch) ? LimFetch : LimWide));
  assign last    = (op_q == OpFetch) ? (cnt_q == 3'd3) : (cnt_q == 3'd7);
  assign mem_idx = addr_q + MemAw'(cnt_q);
  assign rd_byte = bytes[mem_idx];
  assign mem_we  = !reset && (state_q == StAccess) && (op_q == OpStore);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      bytes[mem_idx] <= wdata_q[63:56];
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr[MemAw-1:0];
          wdata_d = req_wdata;
          cnt_d   = '0;
          shift_d = '0;
          if (acc_err) begin
            state_d = StResp;
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        shift_d = {shift_q[55:0], rd_byte};
        // Store data is consumed MSB-first by shifting it up one byte per cycle.
        wdata_d = {wdata_q[55:0], 8'h00};
        cnt_d   = cnt_q + 3'd1;
        if (last) begin
          state_d = StResp;
          err_d   = 1'b0;
          if (op_q == OpStore) begin
            rdata_d = '0;
          end else if (op_q == OpFetch) begin
            rdata_d = {32'b0, shift_d[31:0]};
          end else begin
            rdata_d = shift_d;
          end
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == StIdle) && !reset;
    resp_valid = (state_q == StResp);
    busy       = (state_q != StIdle);
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end

endmodule

// File: tb/tb_tinker_mem_responder.sv
// Directed bench for tinker_mem_responder: hand-computed responses, latencies and
// backdoor memory contents.
module tb_tinker_mem_responder;

  localparam int unsigned MemSize = 524288;
  localparam int unsigned AddrW   = 64;

  logic             clk;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [AddrW-1:0] req_addr;
  logic [63:0]      req_wdata;
  logic             resp_valid;
  logic             resp_ready;
  logic [63:0]      resp_rdata;
  logic             resp_err;
  logic             busy;

  int n_checks;
  int n_errors;

  tinker_mem_responder #(
    .MEM_SIZE(MemSize),
    .ADDR_W  (AddrW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE; exp_lat counts clock edges from the accept edge to the
  // first cycle with resp_valid high (0 means visible in the cycle right after accept).
  task automatic do_req(input string tag, input logic [1:0] op, input logic [63:0] addr,
                        input logic [63:0] wdata, input int exp_lat,
                        input logic [63:0] exp_rdata, input logic exp_err);
    int lat;
    check({tag, " req_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    step();
    req_valid = 1'b0;
    check({tag, " busy"}, 64'(busy), 64'd1);
    lat = 0;
    while (!resp_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " rdata"}, resp_rdata, exp_rdata);
    check({tag, " err"}, 64'(resp_err), 64'(exp_err));
    step();
    check({tag, " valid drop"}, 64'(resp_valid), 64'd0);
  endtask

  initial begin
    int seen;
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    step();
    step();
    check("reset req_ready", 64'(req_ready), 64'd0);
    check("reset resp_valid", 64'(resp_valid), 64'd0);
    check("reset rdata", resp_rdata, 64'd0);
    check("reset err", 64'(resp_err), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    reset = 1'b0;
    #1;
    check("post-reset req_ready", 64'(req_ready), 64'd1);

    // Store then load back
    do_req("store64", 2'b10, 64'h10000, 64'h0123456789ABCDEF, 8, 64'd0, 1'b0);
    check("store byte0", 64'(dut.bytes[32'h10000]), 64'h01);
    check("store byte7", 64'(dut.bytes[32'h10007]), 64'hEF);
    do_req("load64", 2'b01, 64'h10000, 64'd0, 8, 64'h0123456789ABCDEF, 1'b0);

    // Aligned and unaligned fetch
    dut.bytes[32'h2000] = 8'h12;
    dut.bytes[32'h2001] = 8'h34;
    dut.bytes[32'h2002] = 8'h56;
    dut.bytes[32'h2003] = 8'h78;
    dut.bytes[32'h2004] = 8'h9A;
    do_req("fetch32", 2'b00, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 4, 64'h12345678, 1'b0);
    do_req("fetch unaligned", 2'b00, 64'h2001, 64'd0, 4, 64'h3456789A, 1'b0);

    // Legal accesses touching the last byte of the store
    for (int i = 0; i < 8; i++) dut.bytes[MemSize - 8 + i] = 8'(8'h11 * (i + 1));
    do_req("load top", 2'b01, 64'(MemSize - 8), 64'd0, 8, 64'h1122334455667788, 1'b0);
    do_req("fetch top", 2'b00, 64'(MemSize - 4), 64'd0, 4, 64'h55667788, 1'b0);

    // Range and illegal-op errors respond immediately without touching memory
    do_req("load range", 2'b01, 64'(MemSize - 4), 64'd0, 0, 64'd0, 1'b1);
    do_req("fetch range", 2'b00, 64'(MemSize - 3), 64'd0, 0, 64'd0, 1'b1);
    do_req("store overflow", 2'b10, 64'hFFFF_FFFF_FFFF_FFFC, 64'hDEAD_BEEF_DEAD_BEEF, 0,
           64'd0, 1'b1);
    check("overflow mem unchanged", 64'(dut.bytes[MemSize - 4]), 64'h55);
    check("overflow mem unchanged 2", 64'(dut.bytes[MemSize - 1]), 64'h88);
    do_req("illegal op", 2'b11, 64'h10000, 64'h0, 0, 64'd0, 1'b1);
    check("illegal mem unchanged", 64'(dut.bytes[32'h10000]), 64'h01);

    // Backpressure with a second request already pending
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_op     = 2'b01;
    req_addr   = 64'h10000;
    step();
    req_op   = 2'b00;
    req_addr = 64'h2000;
    for (int i = 0; i < 7; i++) step();
    check("bp valid early", 64'(resp_valid), 64'd0);
    step();
    check("bp valid", 64'(resp_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp hold valid", 64'(resp_valid), 64'd1);
      check("bp hold rdata", resp_rdata, 64'h0123456789ABCDEF);
      check("bp hold err", 64'(resp_err), 64'd0);
      check("bp req_ready", 64'(req_ready), 64'd0);
      step();
    end
    resp_ready = 1'b1;
    step();
    check("bp idle after handshake", 64'(busy), 64'd0);
    check("bp valid drop", 64'(resp_valid), 64'd0);
    step();
    req_valid = 1'b0;
    check("bp second accepted", 64'(busy), 64'd1);
    seen = 0;
    while (!resp_valid && seen < 20) begin
      step();
      seen++;
    end
    check("bp second latency", 64'(seen), 64'd4);
    check("bp second rdata", resp_rdata, 64'h12345678);
    step();

    // Reset in the middle of a store
    for (int i = 0; i < 8; i++) dut.bytes[32'h3000 + i] = 8'h00;
    req_valid = 1'b1;
    req_op    = 2'b10;
    req_addr  = 64'h3000;
    req_wdata = 64'hAABBCCDDEEFF1122;
    step();
    req_valid = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("abort req_ready", 64'(req_ready), 64'd1);
    check("abort busy", 64'(busy), 64'd0);
    check("abort byte0", 64'(dut.bytes[32'h3000]), 64'hAA);
    check("abort byte1", 64'(dut.bytes[32'h3001]), 64'hBB);
    check("abort byte2", 64'(dut.bytes[32'h3002]), 64'hCC);
    for (int i = 3; i < 8; i++) check("abort untouched", 64'(dut.bytes[32'h3000 + i]), 64'h00);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (resp_valid) seen++;
      step();
    end
    check("abort no response", 64'(seen), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
